// File: rtl/fr_gen_v1_0_if.sv
// AXI4-Lite register bus for fr_gen_v1_0; the generator takes the slave view.
interface fr_gen_v1_0_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
);
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/fr_gen_v1_0.sv
// AXI4-Lite programmable square-wave generator: continuous or N-cycle burst on fout,
// with running/done status and an emitted-cycle counter.
module fr_gen_v1_0 #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
    input  logic         s00_axi_aclk,
    input  logic         s00_axi_aresetn,
    fr_gen_v1_0_if.slave s00_axi,
    output logic         fout,
    output logic         running
);
    localparam int unsigned DW = C_S00_AXI_DATA_WIDTH;
    localparam int unsigned AW = C_S00_AXI_ADDR_WIDTH;
    localparam int unsigned NB = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic clk;
    logic rst_n;
    assign clk   = s00_axi_aclk;
    assign rst_n = s00_axi_aresetn;

    // Register file
    logic [1:0]    ctrl;
    logic [DW-1:0] half;
    logic [DW-1:0] ncyc;

    // Generator state
    state_t        state;
    state_t        state_nxt;
    logic          fout_nxt;
    logic          running_nxt;
    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_nxt;
    logic [DW-1:0] count;
    logic [DW-1:0] count_nxt;
    logic [DW-1:0] count_inc_c;
    logic [DW-1:0] h_reload_c;
    logic          done;
    logic          done_nxt;
    logic          pol_lat;
    logic          pol_nxt;

    // AXI channel control
    logic          wr_fire_c;
    logic          rd_fire_c;
    logic [1:0]    wr_sel_c;
    logic [1:0]    rd_sel_c;
    logic [DW-1:0] rd_mux_c;
    logic          unused_c;

    assign wr_sel_c = s00_axi.awaddr[AW-1:AW-2];
    assign rd_sel_c = s00_axi.araddr[AW-1:AW-2];

    // The ready pulse itself blocks re-acceptance while the master still holds valid.
    assign wr_fire_c = s00_axi.awvalid && s00_axi.wvalid && !s00_axi.bvalid && !s00_axi.awready;
    assign rd_fire_c = s00_axi.arvalid && !s00_axi.rvalid && !s00_axi.arready;

    assign s00_axi.bresp = 2'b00;
    assign s00_axi.rresp = 2'b00;

    assign unused_c = ^{s00_axi.awprot, s00_axi.arprot,
                        s00_axi.awaddr[AW-3:0], s00_axi.araddr[AW-3:0], count[DW-1:DW-2]};

    function automatic logic [DW-1:0] merge_strb(input logic [DW-1:0] cur,
                                                 input logic [DW-1:0] data,
                                                 input logic [NB-1:0] strb);
        logic [DW-1:0] res;
        res = cur;
        for (int i = 0; i < int'(NB); i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = data[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // Write address/data acceptance and response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s00_axi.awready <= 1'b0;
            s00_axi.wready  <= 1'b0;
            s00_axi.bvalid  <= 1'b0;
        end else begin
            s00_axi.awready <= wr_fire_c;
            s00_axi.wready  <= wr_fire_c;
            if (s00_axi.awready) begin
                s00_axi.bvalid <= 1'b1;
            end else if (s00_axi.bvalid && s00_axi.bready) begin
                s00_axi.bvalid <= 1'b0;
            end
        end
    end

    // Register writes; STATUS is read-only and silently ignores writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= 2'b00;
            half <= DW'(1);
            ncyc <= '0;
        end else if (wr_fire_c) begin
            case (wr_sel_c)
                2'd0: if (s00_axi.wstrb[0]) ctrl <= s00_axi.wdata[1:0];
                2'd1: half <= merge_strb(half, s00_axi.wdata, s00_axi.wstrb);
                2'd2: ncyc <= merge_strb(ncyc, s00_axi.wdata, s00_axi.wstrb);
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux_c = '0;
        case (rd_sel_c)
            2'd0:    rd_mux_c = DW'(ctrl);
            2'd1:    rd_mux_c = half;
            2'd2:    rd_mux_c = ncyc;
            default: rd_mux_c = DW'({count[DW-3:0], done, running});
        endcase
    end

    // Read channel: rdata frozen from capture until rready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s00_axi.arready <= 1'b0;
            s00_axi.rvalid  <= 1'b0;
            s00_axi.rdata   <= '0;
        end else begin
            s00_axi.arready <= rd_fire_c;
            if (rd_fire_c) begin
                s00_axi.rdata <= rd_mux_c;
            end
            if (s00_axi.arready) begin
                s00_axi.rvalid <= 1'b1;
            end else if (s00_axi.rvalid && s00_axi.rready) begin
                s00_axi.rvalid <= 1'b0;
            end
        end
    end

    // Reload value h-1, with HALF=0 treated as a half-period of one cycle
    assign h_reload_c = (half == '0) ? '0 : half - DW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            fout    <= 1'b0;
            running <= 1'b0;
            cnt     <= '0;
            count   <= '0;
            done    <= 1'b0;
            pol_lat <= 1'b0;
        end else begin
            state   <= state_nxt;
            fout    <= fout_nxt;
            running <= running_nxt;
            cnt     <= cnt_nxt;
            count   <= count_nxt;
            done    <= done_nxt;
            pol_lat <= pol_nxt;
        end
    end

    // Level timing: cnt is loaded only at start and on each toggle, so HALF writes
    // never disturb the level already in progress.
    always_comb begin
        state_nxt   = state;
        fout_nxt    = fout;
        running_nxt = running;
        cnt_nxt     = cnt;
        count_nxt   = count;
        done_nxt    = done;
        pol_nxt     = pol_lat;
        count_inc_c = count + DW'(1);

        unique case (state)
            S_IDLE: begin
                fout_nxt    = ctrl[1];
                running_nxt = 1'b0;
                if (ctrl[0]) begin
                    state_nxt   = S_RUN;
                    pol_nxt     = ctrl[1];
                    fout_nxt    = !ctrl[1];
                    running_nxt = 1'b1;
                    cnt_nxt     = h_reload_c;
                    count_nxt   = '0;
                    done_nxt    = 1'b0;
                end
            end
            S_RUN: begin
                if (!ctrl[0]) begin
                    state_nxt   = S_IDLE;
                    fout_nxt    = ctrl[1];
                    running_nxt = 1'b0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - DW'(1);
                end else begin
                    fout_nxt = !fout;
                    cnt_nxt  = h_reload_c;
                    if ((!fout) == pol_lat) begin
                        count_nxt = count_inc_c;
                        if ((ncyc != '0) && (count_inc_c == ncyc)) begin
                            state_nxt   = S_DONE;
                            fout_nxt    = pol_lat;
                            running_nxt = 1'b0;
                            done_nxt    = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                fout_nxt    = pol_lat;
                running_nxt = 1'b0;
                done_nxt    = 1'b1;
                if (!ctrl[0]) begin
                    state_nxt = S_IDLE;
                    fout_nxt  = ctrl[1];
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_fr_gen_v1_0.sv
// Directed self-checking bench for fr_gen_v1_0: register access, waveform timing,
// burst termination, polarity and AXI back-pressure.
module tb_fr_gen_v1_0;
    logic clk = 1'b0;
    logic rst_n;
    logic fout;
    logic running;

    always #10 clk = ~clk;

    fr_gen_v1_0_if #(.DW(32), .AW(4)) bus ();

    fr_gen_v1_0 #(
        .C_S00_AXI_DATA_WIDTH(32),
        .C_S00_AXI_ADDR_WIDTH(4)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(rst_n),
        .s00_axi        (bus),
        .fout           (fout),
        .running        (running)
    );

    int total = 0;
    int bad   = 0;

    bit mon_on = 1'b0;
    bit mon[$];
    int runs[$];

    always @(negedge clk) if (mon_on) mon.push_back(fout);

    initial begin
        #200us;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic void build_runs();
        int len;
        runs.delete();
        if (mon.size() == 0) return;
        len = 1;
        for (int i = 1; i < mon.size(); i++) begin
            if (mon[i] == mon[i-1]) len++;
            else begin
                runs.push_back(len);
                len = 1;
            end
        end
        runs.push_back(len);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(posedge clk); #1;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(bus.awready && bus.wready) && n < 20);
        chk("wr_ready", {30'b0, bus.awready, bus.wready}, 32'h3);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 20) begin @(posedge clk); #1; n++; end
        chk("wr_bvalid", 32'(bus.bvalid), 32'h1);
        chk("wr_bresp", 32'(bus.bresp), 32'h0);
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n;
        @(posedge clk); #1;
        bus.araddr = a; bus.arvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.arready && n < 20);
        chk("rd_arready", 32'(bus.arready), 32'h1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        n = 0;
        while (!bus.rvalid && n < 20) begin @(posedge clk); #1; n++; end
        chk("rd_rvalid", 32'(bus.rvalid), 32'h1);
        chk("rd_rresp", 32'(bus.rresp), 32'h0);
        d = bus.rdata;
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int n;
        int nbad;
        int nbad2;
        int nbad3;

        rst_n = 1'b0;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fout", 32'(fout), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_hs", {26'b0, bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, 1'b0}, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        rst_n = 1'b1;

        axi_read(4'h0, d); chk("rst_ctrl", d, 32'h0);
        axi_read(4'h4, d); chk("rst_half", d, 32'h1);
        axi_read(4'h8, d); chk("rst_ncyc", d, 32'h0);
        axi_read(4'hC, d); chk("rst_status", d, 32'h0);

        // Continuous, HALF=6: levels of 6, period 12
        axi_write(4'h4, 32'd6, 4'hF);
        axi_write(4'h8, 32'd0, 4'hF);
        mon.delete(); mon_on = 1'b1;
        axi_write(4'h0, 32'h1, 4'hF);
        repeat (60) @(posedge clk);
        #1;
        mon_on = 1'b0;
        chk("h6_running", 32'(running), 32'h1);
        build_runs();
        nbad = 0;
        for (int i = 1; i < runs.size() - 1; i++) if (runs[i] != 6) nbad++;
        chk("h6_levels", 32'(nbad), 32'h0);
        chk("h6_enough_levels", 32'(runs.size() >= 8), 32'h1);
        chk("h6_period", 32'(runs[1] + runs[2]), 32'd12);
        axi_write(4'h0, 32'h0, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        chk("h6_stop_fout", 32'(fout), 32'h0);
        chk("h6_stop_running", 32'(running), 32'h0);

        // Burst of 4 cycles, HALF=3
        axi_write(4'h4, 32'd3, 4'hF);
        axi_write(4'h8, 32'd4, 4'hF);
        mon.delete(); mon_on = 1'b1;
        axi_write(4'h0, 32'h1, 4'hF);
        repeat (40) @(posedge clk);
        #1;
        mon_on = 1'b0;
        build_runs();
        chk("burst_nlevels", 32'(runs.size()), 32'd9);
        nbad = 0;
        for (int i = 1; i < 8; i++) if (runs[i] != 3) nbad++;
        chk("burst_levels", 32'(nbad), 32'h0);
        chk("burst_fout", 32'(fout), 32'h0);
        chk("burst_running", 32'(running), 32'h0);
        axi_read(4'hC, d); chk("burst_status", d, 32'h12);
        axi_write(4'h0, 32'h0, 4'hF);

        // POL=1: idle high, first level low for HALF cycles
        axi_write(4'h8, 32'd0, 4'hF);
        axi_write(4'h4, 32'd2, 4'hF);
        axi_write(4'h0, 32'h2, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        chk("pol_idle", 32'(fout), 32'h1);
        axi_read(4'hC, d); chk("pol_done_kept", d & 32'h3, 32'h2);
        mon.delete(); mon_on = 1'b1;
        axi_write(4'h0, 32'h3, 4'hF);
        repeat (12) @(posedge clk);
        axi_write(4'h0, 32'h2, 4'hF);
        #1;
        mon_on = 1'b0;
        chk("pol_stop_fout", 32'(fout), 32'h1);
        chk("pol_stop_running", 32'(running), 32'h0);
        build_runs();
        chk("pol_first_low", 32'(runs[1]), 32'd2);
        chk("pol_second_high", 32'(runs[2]), 32'd2);
        axi_read(4'hC, d); chk("pol_done_cleared", d & 32'h3, 32'h0);

        // HALF change mid-level: current level keeps 5, later levels use 2
        axi_write(4'h0, 32'h0, 4'hF);
        axi_write(4'h4, 32'd5, 4'hF);
        mon.delete(); mon_on = 1'b1;
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'd2, 4'hF);
        repeat (20) @(posedge clk);
        #1;
        mon_on = 1'b0;
        build_runs();
        chk("shadow_first", 32'(runs[1]), 32'd5);
        nbad = 0;
        for (int i = 2; i < runs.size() - 1; i++) if (runs[i] != 2) nbad++;
        chk("shadow_later", 32'(nbad), 32'h0);
        chk("shadow_nlevels", 32'(runs.size() >= 8), 32'h1);

        // HALF=0 behaves as 1: toggle every cycle
        axi_write(4'h4, 32'd0, 4'hF);
        repeat (4) @(posedge clk);
        mon.delete(); mon_on = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        mon_on = 1'b0;
        build_runs();
        chk("half0_levels", 32'(runs.size()), 32'd10);
        axi_write(4'h0, 32'h0, 4'hF);

        // Byte strobes
        axi_write(4'h4, 32'h100, 4'hF);
        axi_write(4'h4, 32'hAABBCC07, 4'h1);
        axi_read(4'h4, d); chk("wstrb_half", d, 32'h107);

        // STATUS write is ignored
        axi_write(4'hC, 32'hFFFFFFFF, 4'hF);
        axi_read(4'h4, d); chk("status_wr_half", d, 32'h107);
        axi_read(4'h0, d); chk("status_wr_ctrl", d, 32'h0);

        // Write response back-pressure: no second acceptance while bvalid held
        @(posedge clk); #1;
        bus.awaddr = 4'h4; bus.wdata = 32'h222; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.awready && n < 20);
        chk("bp_aw", 32'(bus.awready), 32'h1);
        @(posedge clk); #1;
        bus.wdata = 32'h55;
        nbad = 0; nbad2 = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!bus.bvalid) nbad++;
            if (bus.awready || bus.wready) nbad2++;
        end
        chk("bp_bvalid_held", 32'(nbad), 32'h0);
        chk("bp_no_second_aw", 32'(nbad2), 32'h0);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        @(posedge clk); #1;
        chk("bp_b_release", 32'(bus.bvalid), 32'h0);
        bus.bready = 1'b0;
        axi_read(4'h4, d); chk("bp_half", d, 32'h222);

        // Read back-pressure: rdata stable, no second acceptance
        @(posedge clk); #1;
        bus.araddr = 4'h4; bus.arvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.arready && n < 20);
        chk("rbp_ar", 32'(bus.arready), 32'h1);
        @(posedge clk); #1;
        bus.araddr = 4'h0;
        chk("rbp_rdata", bus.rdata, 32'h222);
        nbad = 0; nbad2 = 0; nbad3 = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!bus.rvalid) nbad++;
            if (bus.rdata !== 32'h222) nbad2++;
            if (bus.arready) nbad3++;
        end
        chk("rbp_rvalid_held", 32'(nbad), 32'h0);
        chk("rbp_rdata_stable", 32'(nbad2), 32'h0);
        chk("rbp_no_second_ar", 32'(nbad3), 32'h0);
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        @(posedge clk); #1;
        chk("rbp_r_release", 32'(bus.rvalid), 32'h0);
        bus.rready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
